// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle RV32I subset core.
// Each instruction is stepped through FETCH/DECODE/execute/memory/writeback
// states. The FSM drives the datapath selects and write enables, and it
// counts retired instructions.
module multicycle_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // Raw per-state decode, before derived outputs and reset gating
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       illegal_op;
  logic       retire;
  logic       state_valid;
  logic [2:0] alu_ctl;
  logic [1:0] imm_src;

  // State and retired-instruction counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d     = S_FETCH;
    pc_update   = 1'b0;
    branch      = 1'b0;
    alu_op      = 2'b00;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    illegal_op  = 1'b0;
    retire      = 1'b0;
    state_valid = 1'b1;
    case (state_q)
      S_FETCH: begin
        state_d    = S_DECODE;
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECR;
          OP_ITYP:      state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      S_EXECR: begin
        state_d   = S_ALUWB;
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        state_d   = S_ALUWB;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        retire    = 1'b1;
      end
      default: begin
        // Unreachable encodings recover to FETCH with everything quiet
        state_d     = S_FETCH;
        state_valid = 1'b0;
      end
    endcase
  end

  // Retire count advances on the edge leaving a final instruction state
  always_comb begin
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // ALU operation decode from ALUOp and the instruction function fields
  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      2'b00: alu_ctl = ALU_ADD;
      2'b01: alu_ctl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_ctl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctl = ALU_SLT;
          3'b110:  alu_ctl = ALU_OR;
          3'b111:  alu_ctl = ALU_AND;
          default: alu_ctl = ALU_ADD;
        endcase
      end
    endcase
  end

  // Immediate format follows the opcode in every state so the extender is ready after DECODE
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Output drive; reset forces every output low so nothing is written during reset
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 2'b00;
    illegal    = 1'b0;
    instret    = '0;
    if (!RST) begin
      PCWrite    = pc_update | (branch & Zero);
      AdrSrc     = adr_src;
      MemWrite   = mem_write;
      IRWrite    = ir_write;
      RegWrite   = reg_write;
      ResultSrc  = result_src;
      ALUSrcA    = alu_src_a;
      ALUSrcB    = alu_src_b;
      ALUControl = state_valid ? alu_ctl : 3'b000;
      ImmSrc     = state_valid ? imm_src : 2'b00;
      illegal    = illegal_op;
      instret    = instret_q;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed plus randomized instruction stream checked
// against an instruction-level model of the control unit.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [6:0]  op = 7'b0;
  logic [2:0]  funct3 = 3'b0;
  logic        funct7b5 = 1'b0;
  logic        Zero = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instret = 32'd0;

  typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AW, P_BQ, P_J} phase_e;

  multicycle_ctrl dut (
    .CLK(CLK), .RST(RST), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .instret(instret)
  );

  always #5 CLK = ~CLK;

  function automatic bit is_legal(input logic [6:0] o);
    return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
           (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
  endfunction

  // Arithmetic/logic operation the ALU should perform for an R/I instruction
  function automatic logic [2:0] func_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected output vector for one cycle of an instruction
  function automatic logic [31:0] exp_out(input phase_e ph, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7, input logic z);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 0; sa = 0; sb = 0; alu = 3'b000;
    imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
          (o == 7'b1101111) ? 2'b11 : 2'b00;
    case (ph)
      P_F:   begin irw = 1; pcw = 1; sb = 2; rs = 2; end
      P_D:   begin sa = 1; sb = 1; ill = !is_legal(o); end
      P_MA:  begin sa = 2; sb = 1; end
      P_MR:  adr = 1;
      P_MWB: begin rs = 1; rw = 1; end
      P_MW:  begin adr = 1; mw = 1; end
      P_ER:  begin sa = 2; alu = func_alu(o, f3, f7); end
      P_EI:  begin sa = 2; sb = 1; alu = func_alu(o, f3, f7); end
      P_AW:  rw = 1;
      P_BQ:  begin sa = 2; alu = 3'b001; pcw = z; end
      P_J:   begin sa = 1; sb = 2; pcw = 1; end
      default: ;
    endcase
    return {15'b0, pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
  endfunction

  function automatic logic [31:0] obs_out();
    return {15'b0, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ALUControl, ImmSrc, illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Runs one instruction; zmode 0/1 fixes Zero, 2 randomizes it each cycle.
  // rst_at >= 0 asserts RST for two cycles at that phase, abandoning the instruction.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zmode, input int rst_at, input bit force_wrap);
    phase_e seq[$];
    seq = '{P_F, P_D};
    case (o)
      7'b0000011: seq = '{P_F, P_D, P_MA, P_MR, P_MWB};
      7'b0100011: seq = '{P_F, P_D, P_MA, P_MW};
      7'b0110011: seq = '{P_F, P_D, P_ER, P_AW};
      7'b0010011: seq = '{P_F, P_D, P_EI, P_AW};
      7'b1100011: seq = '{P_F, P_D, P_BQ};
      7'b1101111: seq = '{P_F, P_D, P_J};
      default:    seq = '{P_F, P_D};
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge CLK);
      op = o; funct3 = f3; funct7b5 = f7;
      Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      if (i == rst_at) begin
        RST = 1'b1;
        #1;
        chk($sformatf("%s rst1 outputs", name), obs_out(), 32'd0);
        chk($sformatf("%s rst1 instret", name), instret, 32'd0);
        @(negedge CLK);
        #1;
        chk($sformatf("%s rst2 outputs", name), obs_out(), 32'd0);
        chk($sformatf("%s rst2 instret", name), instret, 32'd0);
        exp_instret = 32'd0;
        @(posedge CLK);
        #1 RST = 1'b0;
        return;
      end
      #1;
      chk($sformatf("%s cyc%0d outputs", name, i), obs_out(), exp_out(seq[i], o, f3, f7, Zero));
      chk($sformatf("%s cyc%0d instret", name, i), instret, exp_instret);
      if (force_wrap && i == seq.size() - 1) begin
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        chk($sformatf("%s preload instret", name), instret, exp_instret);
      end
      if (i == seq.size() - 1 && is_legal(o)) exp_instret = exp_instret + 32'd1;
    end
  endtask

  initial begin
    logic [6:0] rop;
    int cls;
    // Power-on reset held for two cycles
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      #1;
      chk("por outputs", obs_out(), 32'd0);
      chk("por instret", instret, 32'd0);
    end
    @(posedge CLK);
    #1 RST = 1'b0;

    // Directed cases
    run_instr("lw_abort", 7'b0000011, 3'b010, 1'b0, 0, 4, 1'b0);
    run_instr("lw",       7'b0000011, 3'b010, 1'b0, 0, -1, 1'b0);
    run_instr("sw",       7'b0100011, 3'b010, 1'b0, 0, -1, 1'b0);
    run_instr("r_sub",    7'b0110011, 3'b000, 1'b1, 0, -1, 1'b0);
    run_instr("i_add",    7'b0010011, 3'b000, 1'b1, 0, -1, 1'b0);
    run_instr("r_or",     7'b0110011, 3'b110, 1'b0, 0, -1, 1'b0);
    run_instr("r_and",    7'b0110011, 3'b111, 1'b0, 0, -1, 1'b0);
    run_instr("i_slt",    7'b0010011, 3'b010, 1'b0, 0, -1, 1'b0);
    run_instr("beq_nt",   7'b1100011, 3'b000, 1'b0, 0, -1, 1'b0);
    run_instr("beq_t",    7'b1100011, 3'b000, 1'b0, 1, -1, 1'b0);
    run_instr("illegal",  7'b1111111, 3'b000, 1'b0, 0, -1, 1'b0);
    run_instr("jal",      7'b1101111, 3'b000, 1'b0, 2, -1, 1'b0);

    // Randomized instruction stream with occasional mid-instruction resets
    for (int n = 0; n < 300; n++) begin
      cls = int'($urandom_range(0, 6));
      case (cls)
        0: rop = 7'b0000011;
        1: rop = 7'b0100011;
        2: rop = 7'b0110011;
        3: rop = 7'b0010011;
        4: rop = 7'b1100011;
        5: rop = 7'b1101111;
        default: begin
          rop = 7'($urandom_range(0, 127));
          while (is_legal(rop)) rop = 7'($urandom_range(0, 127));
        end
      endcase
      run_instr($sformatf("rnd%0d", n), rop, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 2,
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 1)) : -1, 1'b0);
    end

    // Counter wrap from all-ones on a retiring jal
    run_instr("jal_wrap", 7'b1101111, 3'b000, 1'b0, 2, -1, 1'b1);
    @(negedge CLK);
    #1;
    chk("wrap instret", instret, 32'd0);
    chk("wrap instret model", instret, exp_instret);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
